// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types and reset defaults for the clkgen_multi block.
// The per-channel config struct is sized by CFG_W; clkgen_multi's CNT_W
// defaults to it, so a wider counter means editing CFG_W here.
package clkgen_pkg;

    localparam int CFG_W = 16;

    localparam logic [CFG_W-1:0] DIV_RST   = CFG_W'(2);
    localparam logic [CFG_W-1:0] HIGH_RST  = CFG_W'(1);
    localparam logic [CFG_W-1:0] PHASE_RST = CFG_W'(0);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_START,
        ST_SETTLE,
        ST_LOCKED,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } cfg_t;

    localparam cfg_t CFG_RST = '{div: DIV_RST, high: HIGH_RST, phase: PHASE_RST};

    // A channel setting is usable when the period holds at least one high
    // and one low cycle and the start delay fits inside one period.
    function automatic logic cfg_ok(input cfg_t c);
        return (c.div >= CFG_W'(2)) && (c.high != '0) &&
               (c.high < c.div) && (c.phase < c.div);
    endfunction

endpackage

// File: rtl/clkgen_chan.sv
// clkgen_chan: one divided-clock channel. Holds its own active copy of
// div/high (latched at START) so the top's shadow registers can change while
// the channel keeps running on the old setting. cnt is the period position of
// the cycle currently shown on outclk; START parks it at div-1 so the first
// running edge after the delay begins a fresh period.
module clkgen_chan
    import clkgen_pkg::*;
(
    input  logic refclk,
    input  logic rst,
    input  logic load,
    input  logic run,
    input  logic drain,
    input  cfg_t cfg,
    output logic outclk,
    output logic at_end,
    output logic dly_done
);

    logic [CFG_W-1:0] div_a;
    logic [CFG_W-1:0] high_a;
    logic [CFG_W-1:0] delay;
    logic [CFG_W-1:0] cnt;
    logic [CFG_W-1:0] cnt_nxt;
    logic             step;

    assign dly_done = (delay == '0);
    // Safe point to stop: output low and either still waiting out the phase
    // delay or showing the last (low) cycle of the period.
    assign at_end   = !outclk && (!dly_done || (cnt == div_a - 1'b1));
    // While draining, a channel that reached its safe point parks there so
    // no new high pulse can start before the restart.
    assign step     = run && !(drain && at_end);
    assign cnt_nxt  = (cnt == div_a - 1'b1) ? '0 : cnt + 1'b1;

    // Delay countdown, period counter and registered output.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            div_a  <= DIV_RST;
            high_a <= HIGH_RST;
            delay  <= PHASE_RST;
            cnt    <= DIV_RST - 1'b1;
            outclk <= 1'b0;
        end else if (load) begin
            div_a  <= cfg.div;
            high_a <= cfg.high;
            delay  <= cfg.phase;
            cnt    <= cfg.div - 1'b1;
            outclk <= 1'b0;
        end else if (step) begin
            if (!dly_done) begin
                delay  <= delay - 1'b1;
                outclk <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                outclk <= (cnt_nxt < high_a);
            end
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CLK programmable divided clocks from refclk with a lock
// indication. Holds the restart FSM, write validation, shadow registers and
// the settle counter; per-channel counters live in clkgen_chan.
// Build option CLKGEN_GLITCHFREE_EN: when defined, a valid write first
// drains every channel to a low, end-of-period point before restarting, so
// no high pulse is ever cut short. When undefined, restart is immediate.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int  NUM_CLK     = 2,
    parameter int  CNT_W       = CFG_W,
    parameter int  LOCK_CYCLES = 16,
    localparam int CH_W        = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [CNT_W-1:0]   cfg_phase,
    output logic               cfg_err,
    output logic [NUM_CLK-1:0] outclk,
    output logic               locked
);

    localparam int SET_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(LOCK_CYCLES);

`ifdef CLKGEN_GLITCHFREE_EN
    localparam state_t ST_RESTART = ST_DRAIN;
`else
    localparam state_t ST_RESTART = ST_START;
`endif

    state_t             state;
    logic [SET_W-1:0]   settle;
    cfg_t               shadow [NUM_CLK];
    cfg_t               wr_cfg;
    logic               wr;
    logic               wr_ok;
    logic [NUM_CLK-1:0] at_end;
    logic [NUM_CLK-1:0] dly_done;
    logic               st_start;
    logic               st_run;
    logic               st_drain;

    assign wr_cfg    = '{div: CFG_W'(cfg_div), high: CFG_W'(cfg_high), phase: CFG_W'(cfg_phase)};
    assign cfg_ready = (state == ST_SETTLE) || (state == ST_LOCKED);
    assign wr        = cfg_valid && cfg_ready;
    assign wr_ok     = wr && cfg_ok(wr_cfg) && (int'(cfg_ch) < NUM_CLK);

    assign st_start  = (state == ST_START);
    assign st_run    = (state == ST_SETTLE) || (state == ST_LOCKED) || (state == ST_DRAIN);
`ifdef CLKGEN_GLITCHFREE_EN
    assign st_drain  = (state == ST_DRAIN);
`else
    assign st_drain  = 1'b0;
`endif

    // Shadow registers: take accepted writes, picked up by channels at START.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLK; i++) shadow[i] <= CFG_RST;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_CLK; i++)
                if (CH_W'(i) == cfg_ch) shadow[i] <= wr_cfg;
        end
    end

    // Restart FSM with settle counter, lock flag and reject pulse.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RESET;
            settle  <= '0;
            locked  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= wr && !wr_ok;
            case (state)
                ST_RESET: state <= ST_START;
                ST_START: begin
                    settle <= '0;
                    state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (wr_ok) begin
                        state <= ST_RESTART;
                    end else if ((settle == SET_MAX) && (&dly_done)) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end else if (settle != SET_MAX) begin
                        settle <= settle + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (wr_ok) begin
                        state  <= ST_RESTART;
                        locked <= 1'b0;
                    end
                end
                // Only reachable with the drain option; every channel parks
                // at its safe point, then all restart together.
                ST_DRAIN: if (&at_end) state <= ST_START;
                default:  state <= ST_RESET;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
        clkgen_chan u_chan (
            .refclk   (refclk),
            .rst      (rst),
            .load     (st_start),
            .run      (st_run),
            .drain    (st_drain),
            .cfg      (shadow[i]),
            .outclk   (outclk[i]),
            .at_end   (at_end[i]),
            .dly_done (dly_done[i])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed bench for clkgen_multi (NUM_CLK=2, LOCK_CYCLES=16).
// k counts refclk edges since the most recent START edge; outputs are sampled
// on the falling edge. Expected outclk comes from eb(): low through the phase
// delay, then high for the first `high` cycles of every `div`-cycle period.
module tb_clkgen_multi;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic [15:0] cfg_phase;
    logic        cfg_err;
    logic [1:0]  outclk;
    logic        locked;

    int errors = 0;
    int checks = 0;
    int k      = 0;

    logic [0:0]  bad_ch    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] bad_div   [4] = '{16'd4, 16'd1, 16'd3, 16'd5};
    logic [15:0] bad_high  [4] = '{16'd4, 16'd1, 16'd0, 16'd2};
    logic [15:0] bad_phase [4] = '{16'd0, 16'd0, 16'd1, 16'd5};
`ifdef CLKGEN_GLITCHFREE_EN
    logic [1:0]  drain_exp [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                   2'b00, 2'b00, 2'b00, 2'b00};
`endif

    clkgen_multi #(.NUM_CLK(2), .CNT_W(16), .LOCK_CYCLES(16)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outclk    (outclk),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic eb(input int kk, input int d, input int h, input int p);
        if (kk <= p) return 1'b0;
        return ((kk - p - 1) % d) < h;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge refclk);
            k++;
        end
    endtask

    // Wait for cfg_ready, present one write for a single cycle.
    task automatic wr(input logic [0:0] ch, input logic [15:0] d, input logic [15:0] h,
                      input logic [15:0] p);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        chk1("wr_ready_wait", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_high  = h;
        cfg_phase = p;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    // Wait for the first cycle after a START edge and zero the edge count.
    task automatic sync(input string tag);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        chk1(tag, cfg_ready, 1'b1);
        k = 0;
    endtask

    // Called at the falling edge where rst is released; defaults on both channels.
    task automatic run_boot();
        cyc(1);
        chk1("boot_start_ready", cfg_ready, 1'b0);
        chk2("boot_start_out", outclk, 2'b00);
        cyc(1);
        k = 0;
        chk1("boot_settle_ready", cfg_ready, 1'b1);
        chk2("boot_k0_out", outclk, 2'b00);
        for (int i = 1; i <= 17; i++) begin
            cyc(1);
            chk2($sformatf("boot_out k=%0d", k), outclk, {eb(k, 2, 1, 0), eb(k, 2, 1, 0)});
            chk1($sformatf("boot_locked k=%0d", k), locked, (k >= 17));
        end
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = 16'd0;
        cfg_high  = 16'd0;
        cfg_phase = 16'd0;
        cyc(3);
        chk2("rst_outclk", outclk, 2'b00);
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_ready", cfg_ready, 1'b0);
        chk1("rst_err", cfg_err, 1'b0);

        // Defaults: refclk/2 on both channels, lock after the settle interval.
        rst = 1'b1;
        run_boot();

        // ch1 -> div 5, high 2, phase 3; ch0 stays /2 on the same reference.
        wr(1'b1, 16'd5, 16'd2, 16'd3);
        chk1("wr1_locked_drop", locked, 1'b0);
        chk1("wr1_no_err", cfg_err, 1'b0);
        sync("wr1_sync");
        chk2("wr1_k0_out", outclk, 2'b00);
        for (int i = 1; i <= 18; i++) begin
            cyc(1);
            chk2($sformatf("wr1_out k=%0d", k), outclk, {eb(k, 5, 2, 3), eb(k, 2, 1, 0)});
            chk1($sformatf("wr1_locked k=%0d", k), locked, (k >= 17));
        end

        // Rejected writes: one-cycle error pulse, nothing else moves.
        for (int i = 0; i < 4; i++) begin
            wr(bad_ch[i], bad_div[i], bad_high[i], bad_phase[i]);
            chk1($sformatf("bad%0d_err", i), cfg_err, 1'b1);
            chk1($sformatf("bad%0d_locked", i), locked, 1'b1);
            chk1($sformatf("bad%0d_ready", i), cfg_ready, 1'b1);
            chk2($sformatf("bad%0d_out", i), outclk, {eb(k, 5, 2, 3), eb(k, 2, 1, 0)});
            cyc(1);
            chk1($sformatf("bad%0d_err_clr", i), cfg_err, 1'b0);
            chk2($sformatf("bad%0d_out2", i), outclk, {eb(k, 5, 2, 3), eb(k, 2, 1, 0)});
        end

        // Restart rewriting ch0 only: ch1 must still run its earlier setting.
        wr(1'b0, 16'd2, 16'd1, 16'd0);
        sync("shadow_sync");
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            chk2($sformatf("shadow_out k=%0d", k), outclk, {eb(k, 5, 2, 3), eb(k, 2, 1, 0)});
        end

        // Writes during SETTLE: the settle interval starts over each time.
        wr(1'b1, 16'd2, 16'd1, 16'd0);
        sync("settle1_sync");
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            chk2($sformatf("settle1_out k=%0d", k), outclk, {eb(k, 2, 1, 0), eb(k, 2, 1, 0)});
            chk1($sformatf("settle1_locked k=%0d", k), locked, 1'b0);
        end
        wr(1'b0, 16'd10, 16'd5, 16'd0);
        sync("settle2_sync");
        for (int i = 1; i <= 22; i++) begin
            cyc(1);
            chk2($sformatf("settle2_out k=%0d", k), outclk, {eb(k, 2, 1, 0), eb(k, 10, 5, 0)});
            chk1($sformatf("settle2_locked k=%0d", k), locked, (k >= 17));
        end

        // Reconfigure ch0 (div 10, high 5) while it shows period position 1.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 16'd4;
        cfg_high  = 16'd2;
        cfg_phase = 16'd1;
        cyc(1);
        cfg_valid = 1'b0;
        chk2("recfg_accept_out", outclk, 2'b11);
        chk1("recfg_locked", locked, 1'b0);
        chk1("recfg_ready", cfg_ready, 1'b0);
        chk1("recfg_err", cfg_err, 1'b0);
`ifdef CLKGEN_GLITCHFREE_EN
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            chk2($sformatf("drain_out %0d", i), outclk, drain_exp[i]);
            chk1($sformatf("drain_ready %0d", i), cfg_ready, (i == 8));
        end
`else
        cyc(1);
        chk2("cut_out", outclk, 2'b00);
        chk1("cut_ready", cfg_ready, 1'b1);
`endif
        k = 0;
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            chk2($sformatf("recfg_out k=%0d", k), outclk, {eb(k, 2, 1, 0), eb(k, 4, 2, 1)});
        end

        // Asynchronous reset mid-SETTLE with a channel high.
        #1 rst = 1'b0;
        #1;
        chk2("arst1_outclk", outclk, 2'b00);
        chk1("arst1_locked", locked, 1'b0);
        chk1("arst1_ready", cfg_ready, 1'b0);
        chk1("arst1_err", cfg_err, 1'b0);
        cyc(2);
        rst = 1'b1;
        run_boot();

        // Asynchronous reset just after a restart is accepted (drain or START).
        cyc(1);
        wr(1'b1, 16'd3, 16'd1, 16'd0);
        chk2("arst2_pre_out", outclk, 2'b11);
        chk1("arst2_pre_ready", cfg_ready, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk2("arst2_outclk", outclk, 2'b00);
        chk1("arst2_locked", locked, 1'b0);
        chk1("arst2_ready", cfg_ready, 1'b0);
        cyc(2);
        rst = 1'b1;
        run_boot();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
